regfile_scoreboard: RTL and testbench

//  Parametrised successor of the decode-stage register file: NREAD combinational read

---
 rtl/regfile_scoreboard.sv | 87 ++++++++
 tb/tb_regfile_scoreboard.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file: NREAD combinational read ports with write-through bypass,
// one writeback port, and a per-register pending-write counter for RAW/WAW stalls.
module regfile_scoreboard #(
    parameter int WORD     = 32,
    parameter int REG_SIZE = 5,
    parameter int NREAD    = 2,
    parameter int MAX_PEND = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREAD*REG_SIZE-1:0] raddr,
    input  logic [NREAD-1:0]          rvalid,
    output logic [NREAD*WORD-1:0]     rdata,
    input  logic                      issue_valid,
    input  logic                      issue_wr,
    input  logic [REG_SIZE-1:0]       issue_rd,
    output logic                      stall,
    input  logic                      wb_en,
    input  logic [REG_SIZE-1:0]       wb_addr,
    input  logic [WORD-1:0]           wb_data,
    output logic                      pend_any,
    output logic                      err
);
    localparam int REG_COUNT = 2**REG_SIZE;
    localparam int CNT_W     = $clog2(MAX_PEND + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WORD-1:0]  grf [REG_COUNT];
    logic [CNT_W-1:0] cnt [REG_COUNT];
    logic [NREAD-1:0] hazard;
    logic             wb_live;
    logic             rd_full;
    logic             inc;
    logic             dec;

    // Issue handshake: decode holds issue_valid with its operands; the instruction is
    // taken in the cycle where issue_valid=1 and stall=0, otherwise it must be re-presented.
    assign wb_live = wb_en && (wb_addr != '0);
    assign dec     = wb_live && (cnt[wb_addr] != '0);
    assign rd_full = issue_wr && (issue_rd != '0) && (cnt[issue_rd] == CNT_MAX);
    assign stall   = issue_valid && ((|hazard) || rd_full);
    assign inc     = issue_valid && !stall && issue_wr && (issue_rd != '0);

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [REG_SIZE-1:0] ra;
        logic                bypass;
        assign ra     = raddr[i*REG_SIZE +: REG_SIZE];
        assign bypass = wb_en && (wb_addr == ra);
        assign rdata[i*WORD +: WORD] = (ra == '0) ? '0 : (bypass ? wb_data : grf[ra]);
        // The last outstanding write landing this cycle is forwarded, so it is not a hazard.
        assign hazard[i] = rvalid[i] && (ra != '0) && (cnt[ra] != '0)
                           && !((cnt[ra] == CNT_ONE) && bypass);
    end

    always_comb begin
        pend_any = 1'b0;
        for (int r = 0; r < REG_COUNT; r++) begin
            pend_any = pend_any | (cnt[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                grf[r] <= '0;
                cnt[r] <= '0;
            end
            err <= 1'b0;
        end else begin
            if (wb_live) begin
                grf[wb_addr] <= wb_data;
            end
            if (wb_live && (cnt[wb_addr] == '0)) begin
                err <= 1'b1;
            end
            if (!(inc && dec && (issue_rd == wb_addr))) begin
                if (inc) begin
                    cnt[issue_rd] <= cnt[issue_rd] + CNT_ONE;
                end
                if (dec) begin
                    cnt[wb_addr] <= cnt[wb_addr] - CNT_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus randomized traffic checked
// against a reference model built from per-register pending counts and a value array.
module tb_regfile_scoreboard;
    localparam int WORD      = 32;
    localparam int REG_SIZE  = 5;
    localparam int NREAD     = 2;
    localparam int MAX_PEND  = 3;
    localparam int REG_COUNT = 32;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NREAD*REG_SIZE-1:0] raddr;
    logic [NREAD-1:0]          rvalid;
    logic [NREAD*WORD-1:0]     rdata;
    logic                      issue_valid;
    logic                      issue_wr;
    logic [REG_SIZE-1:0]       issue_rd;
    logic                      stall;
    logic                      wb_en;
    logic [REG_SIZE-1:0]       wb_addr;
    logic [WORD-1:0]           wb_data;
    logic                      pend_any;
    logic                      err;

    int vectors     = 0;
    int miscompares = 0;

    logic [WORD-1:0] m_grf [REG_COUNT];
    int              m_cnt [REG_COUNT];
    logic            m_err = 1'b0;
    logic [WORD-1:0] exp_q[$];

    regfile_scoreboard #(.WORD(WORD), .REG_SIZE(REG_SIZE), .NREAD(NREAD), .MAX_PEND(MAX_PEND)) dut (
        .clk(clk), .reset(reset), .raddr(raddr), .rvalid(rvalid), .rdata(rdata),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd), .stall(stall),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .pend_any(pend_any), .err(err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [WORD-1:0] m_read(input int a);
        if (a == 0) return '0;
        if (wb_en && (int'(wb_addr) == a)) return wb_data;
        return m_grf[a];
    endfunction

    function automatic logic m_stall();
        int a;
        if (!issue_valid) return 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            a = int'(raddr[p*REG_SIZE +: REG_SIZE]);
            if (rvalid[p] && a != 0 && m_cnt[a] > 0 &&
                !(m_cnt[a] == 1 && wb_en && int'(wb_addr) == a)) return 1'b1;
        end
        if (issue_wr && issue_rd != 0 && m_cnt[issue_rd] >= MAX_PEND) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_pend();
        for (int r = 0; r < REG_COUNT; r++) if (m_cnt[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Advance one clock: evaluate the model with the inputs as they stand at the edge.
    task automatic cycle();
        logic s, acc, ret;
        s = m_stall();
        @(posedge clk);
        if (!reset) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                m_grf[r] = '0;
                m_cnt[r] = 0;
            end
            m_err = 1'b0;
        end else begin
            acc = issue_valid && !s && issue_wr && issue_rd != 0;
            ret = wb_en && wb_addr != 0 && m_cnt[wb_addr] != 0;
            if (wb_en && wb_addr != 0) begin
                if (m_cnt[wb_addr] == 0) m_err = 1'b1;
                m_grf[wb_addr] = wb_data;
            end
            if (!(acc && ret && issue_rd == wb_addr)) begin
                if (acc) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
                if (ret) m_cnt[wb_addr] = m_cnt[wb_addr] - 1;
            end
        end
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        raddr = '0; rvalid = '0; issue_valid = 1'b0; issue_wr = 1'b0; issue_rd = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    endtask

    task automatic set_read(input int p, input int a, input logic v);
        raddr[p*REG_SIZE +: REG_SIZE] = REG_SIZE'(a);
        rvalid[p] = v;
    endtask

    task automatic set_issue(input logic v, input logic wr, input int rd);
        issue_valid = v; issue_wr = wr; issue_rd = REG_SIZE'(rd);
    endtask

    task automatic set_wb(input logic en, input int a, input logic [WORD-1:0] d);
        wb_en = en; wb_addr = REG_SIZE'(a); wb_data = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0; idle();
        @(negedge clk);
        cycle();
        reset = 1'b1;
        for (int r = 0; r < REG_COUNT / 2; r++) begin
            set_read(0, r, 1'b1); set_read(1, r + 16, 1'b1);
            #1;
            vectors++;
            if (rdata !== '0) begin
                miscompares++;
                $display("FAIL reset_read r=%0d got=%h want=0", r, rdata);
            end
            cycle();
        end
        idle(); #1;
        vectors++;
        if ({stall, pend_any, err} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags got stall/pend/err=%b want=000", {stall, pend_any, err});
        end
    endtask

    task automatic test_raw_bypass();
        idle(); set_issue(1'b1, 1'b1, 5); #1;
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("FAIL raw_issue got stall=%b want=0", stall); end
        cycle();
        set_issue(1'b1, 1'b0, 0); set_read(0, 5, 1'b1); #1;
        vectors++;
        if (stall !== 1'b1) begin miscompares++; $display("FAIL raw_stall got stall=%b want=1", stall); end
        set_wb(1'b1, 5, 32'hDEADBEEF); #1;
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("FAIL raw_bypass_stall got=%b want=0", stall); end
        vectors++;
        if (rdata[WORD-1:0] !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL raw_bypass_data got=%h want=deadbeef", rdata[WORD-1:0]);
        end
        cycle();
        idle(); set_read(0, 5, 1'b0); #1;
        vectors++;
        if (rdata[WORD-1:0] !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL raw_stored got=%h want=deadbeef", rdata[WORD-1:0]);
        end
        vectors++;
        if (pend_any !== 1'b0) begin miscompares++; $display("FAIL raw_pend got=%b want=0", pend_any); end
    endtask

    task automatic test_waw_limit();
        idle();
        for (int k = 0; k < 3; k++) begin
            set_issue(1'b1, 1'b1, 7); #1;
            vectors++;
            if (stall !== 1'b0) begin miscompares++; $display("FAIL waw_fill k=%0d got=%b want=0", k, stall); end
            cycle();
        end
        set_issue(1'b1, 1'b1, 7); #1;
        vectors++;
        if (stall !== 1'b1) begin miscompares++; $display("FAIL waw_full got=%b want=1", stall); end
        cycle();
        idle(); set_wb(1'b1, 7, 32'h11); cycle();
        idle(); set_issue(1'b1, 1'b1, 7); #1;
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("FAIL waw_after_retire got=%b want=0", stall); end
        cycle();
        #1;
        vectors++;
        if (stall !== 1'b1) begin miscompares++; $display("FAIL waw_refull got=%b want=1", stall); end
        idle();
        for (int k = 0; k < 3; k++) begin
            set_wb(1'b1, 7, WORD'(k)); cycle();
        end
        idle(); #1;
        vectors++;
        if (pend_any !== 1'b0) begin miscompares++; $display("FAIL waw_drain got=%b want=0", pend_any); end
    endtask

    task automatic test_same_cycle();
        idle(); set_issue(1'b1, 1'b1, 9); cycle(); cycle();
        set_wb(1'b1, 9, 32'h99); #1;
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("FAIL same_issue got=%b want=0", stall); end
        cycle();
        idle(); set_issue(1'b1, 1'b0, 0); set_read(1, 9, 1'b1); set_wb(1'b1, 9, 32'h9A); #1;
        vectors++;
        if (stall !== 1'b1) begin miscompares++; $display("FAIL same_cnt2_stall got=%b want=1", stall); end
        cycle();
        #1;
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("FAIL same_cnt1_bypass got=%b want=0", stall); end
        vectors++;
        if (rdata[WORD +: WORD] !== 32'h9A) begin
            miscompares++; $display("FAIL same_bypass_data got=%h want=9a", rdata[WORD +: WORD]);
        end
        cycle();
        idle(); #1;
        vectors++;
        if (pend_any !== 1'b0) begin miscompares++; $display("FAIL same_drain got=%b want=0", pend_any); end
    endtask

    task automatic test_err();
        logic [WORD-1:0] d;
        d = $urandom;
        idle(); set_wb(1'b1, 3, d); cycle();
        idle(); set_read(0, 3, 1'b0); #1;
        vectors++;
        if (err !== 1'b1) begin miscompares++; $display("FAIL err_set got=%b want=1", err); end
        vectors++;
        if (rdata[WORD-1:0] !== d) begin miscompares++; $display("FAIL err_write got=%h want=%h", rdata[WORD-1:0], d); end
        vectors++;
        if (pend_any !== 1'b0) begin miscompares++; $display("FAIL err_cnt got=%b want=0", pend_any); end
        cycle(); cycle();
        vectors++;
        if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got=%b want=1", err); end
        reset = 1'b0; cycle(); reset = 1'b1; #1;
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL err_clear got=%b want=0", err); end
        vectors++;
        if (rdata[WORD-1:0] !== '0) begin miscompares++; $display("FAIL err_grf_clear got=%h want=0", rdata[WORD-1:0]); end
    endtask

    task automatic test_reg_zero();
        idle(); set_issue(1'b1, 1'b1, 12); cycle();
        set_issue(1'b1, 1'b1, 0); set_read(0, 0, 1'b1); set_read(1, 0, 1'b1);
        set_wb(1'b1, 0, 32'd5); #1;
        vectors++;
        if (rdata !== '0) begin miscompares++; $display("FAIL zero_read got=%h want=0", rdata); end
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("FAIL zero_stall got=%b want=0", stall); end
        cycle(); cycle();
        #1;
        vectors++;
        if (rdata !== '0 || stall !== 1'b0) begin
            miscompares++; $display("FAIL zero_after got rdata=%h stall=%b want 0/0", rdata, stall);
        end
        vectors++;
        if ({pend_any, err} !== 2'b10) begin
            miscompares++; $display("FAIL zero_flags got pend/err=%b want=10", {pend_any, err});
        end
        idle(); set_wb(1'b1, 12, 32'hC); cycle();
        idle(); #1;
        vectors++;
        if (pend_any !== 1'b0) begin miscompares++; $display("FAIL zero_drain got=%b want=0", pend_any); end
    endtask

    task automatic test_random();
        logic [WORD-1:0] got, exp;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 79) != 0);
            for (int p = 0; p < NREAD; p++) set_read(p, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            set_issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 7));
            set_wb(1'($urandom_range(0, 2) == 0), $urandom_range(0, 7), $urandom);
            #1;
            for (int p = 0; p < NREAD; p++) exp_q.push_back(m_read(int'(raddr[p*REG_SIZE +: REG_SIZE])));
            for (int p = 0; p < NREAD; p++) begin
                got = rdata[p*WORD +: WORD];
                exp = exp_q.pop_front();
                vectors++;
                if (got !== exp) begin
                    miscompares++; $display("FAIL rand_rdata n=%0d port=%0d got=%h want=%h", n, p, got, exp);
                end
            end
            vectors++;
            if (stall !== m_stall()) begin
                miscompares++; $display("FAIL rand_stall n=%0d got=%b want=%b", n, stall, m_stall());
            end
            vectors++;
            if ({pend_any, err} !== {m_pend(), m_err}) begin
                miscompares++;
                $display("FAIL rand_flags n=%0d got pend/err=%b want=%b", n, {pend_any, err}, {m_pend(), m_err});
            end
            cycle();
        end
        reset = 1'b1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b0;
        idle();
        test_reset();
        test_raw_bypass();
        test_waw_limit();
        test_same_cycle();
        test_err();
        test_reg_zero();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
